// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: combinational read ports, two writeback
// ports and the issue/scoreboard handshake.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NRD*AW-1:0]   ReadRegister;
  logic [NRD*XLEN-1:0] ReadData;
  logic [NRD-1:0]      ReadBusy;
  logic                RegWrite0;
  logic [AW-1:0]       WriteRegister0;
  logic [XLEN-1:0]     WriteData0;
  logic                RegWrite1;
  logic [AW-1:0]       WriteRegister1;
  logic [XLEN-1:0]     WriteData1;
  logic                IssueValid;
  logic [AW-1:0]       IssueRegister;
  logic                IssueReady;
  logic [CW-1:0]       BusyCount;

  modport master (
    output ReadRegister, RegWrite0, WriteRegister0, WriteData0,
           RegWrite1, WriteRegister1, WriteData1, IssueValid, IssueRegister,
    input  ReadData, ReadBusy, IssueReady, BusyCount
  );

  modport slave (
    input  ReadRegister, RegWrite0, WriteRegister0, WriteData0,
           RegWrite1, WriteRegister1, WriteData1, IssueValid, IssueRegister,
    output ReadData, ReadBusy, IssueReady, BusyCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Dual-writeback register file with N combinational read ports, optional
// write-to-read bypass and a per-register busy scoreboard. Register 0 reads zero.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic CLK,
  input logic RESET_N,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);
  localparam logic [AW:0] nregsLim = (AW+1)'(NREGS);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    busy;
  logic [NREGS-1:0]    busyNext;
  logic [CW-1:0]       busyCnt;
  logic [CW-1:0]       busyCntNext;
  logic                wrEn0;
  logic                wrEn1;
  logic                issueOk;
  logic [NRD*XLEN-1:0] rdData;
  logic [NRD-1:0]      rdBusy;

  // Index 0 and indices past the top of a non-power-of-two file are inert.
  function automatic logic inRange(input logic [AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < nregsLim);
  endfunction

  assign wrEn0   = bus.RegWrite0 && inRange(bus.WriteRegister0);
  assign wrEn1   = bus.RegWrite1 && inRange(bus.WriteRegister1);
  assign issueOk = bus.IssueValid && inRange(bus.IssueRegister) &&
                   !busy[bus.IssueRegister];

  // Issue is applied after the writeback clears so a new producer wins.
  always_comb begin
    busyNext    = busy;
    busyCntNext = '0;
    if (wrEn0) busyNext[bus.WriteRegister0] = 1'b0;
    if (wrEn1) busyNext[bus.WriteRegister1] = 1'b0;
    if (issueOk) busyNext[bus.IssueRegister] = 1'b1;
    busyNext[0] = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      busyCntNext = busyCntNext + CW'(busyNext[i]);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      // Port 0 is assigned last so it wins a same-index collision.
      if (wrEn1) regs[bus.WriteRegister1] <= bus.WriteData1;
      if (wrEn0) regs[bus.WriteRegister0] <= bus.WriteData0;
      busy    <= busyNext;
      busyCnt <= busyCntNext;
    end
  end

  always_comb begin
    rdData = '0;
    rdBusy = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] idx;
      idx = bus.ReadRegister[k*AW +: AW];
      if (RESET_N && inRange(idx)) begin
        if (BYPASS != 0 && wrEn0 && bus.WriteRegister0 == idx) begin
          rdData[k*XLEN +: XLEN] = bus.WriteData0;
        end else if (BYPASS != 0 && wrEn1 && bus.WriteRegister1 == idx) begin
          rdData[k*XLEN +: XLEN] = bus.WriteData1;
        end else begin
          rdData[k*XLEN +: XLEN] = regs[idx];
          rdBusy[k]              = busy[idx];
        end
      end
    end
  end

  assign bus.ReadData   = rdData;
  assign bus.ReadBusy   = rdBusy;
  assign bus.IssueReady = !(RESET_N && inRange(bus.IssueRegister) &&
                            busy[bus.IssueRegister]);
  assign bus.BusyCount  = busyCnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised + directed bench for regfile_scoreboard: a 32-entry bypassing
// instance and a 24-entry, 3-port, non-bypassing instance against one model.
module tb_regfile_scoreboard;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NRD(2)) busA();
  regfile_scoreboard_if #(.XLEN(32), .NREGS(24), .NRD(3)) busB();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dutA (
    .CLK(CLK), .RESET_N(RESET_N), .bus(busA.slave));
  regfile_scoreboard #(.XLEN(32), .NREGS(24), .NRD(3), .BYPASS(0)) dutB (
    .CLK(CLK), .RESET_N(RESET_N), .bus(busB.slave));

  int nChecks = 0;
  int nErrors = 0;

  int nRegs [2] = '{32, 24};
  int nRd   [2] = '{2, 3};
  bit byp   [2] = '{1'b1, 1'b0};

  logic [4:0]  rdIdx [2][4];
  bit          we0 [2], we1 [2], iv [2];
  logic [4:0]  w0 [2], w1 [2], ir [2];
  logic [31:0] d0 [2], d1 [2];

  logic [31:0] mReg  [2][32];
  bit          mBusy [2][32];
  bit          inReset = 1'b1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit valid(input int u, input logic [4:0] idx);
    return idx != 0 && int'(idx) < nRegs[u];
  endfunction

  function automatic int countBusy(input int u);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mBusy[u][i]);
    return c;
  endfunction

  function automatic void modelRead(input int u, input logic [4:0] idx,
                                    output logic [31:0] d, output bit b);
    d = '0;
    b = 1'b0;
    if (inReset || !valid(u, idx)) return;
    if (byp[u] && we0[u] && w0[u] == idx) d = d0[u];
    else if (byp[u] && we1[u] && w1[u] == idx) d = d1[u];
    else begin
      d = mReg[u][idx];
      b = mBusy[u][idx];
    end
  endfunction

  task automatic modelUpdate();
    if (inReset) return;
    for (int u = 0; u < 2; u++) begin
      bit ok;
      ok = iv[u] && valid(u, ir[u]) && !mBusy[u][ir[u]];
      if (we1[u] && valid(u, w1[u])) begin mReg[u][w1[u]] = d1[u]; mBusy[u][w1[u]] = 1'b0; end
      if (we0[u] && valid(u, w0[u])) begin mReg[u][w0[u]] = d0[u]; mBusy[u][w0[u]] = 1'b0; end
      if (ok) mBusy[u][ir[u]] = 1'b1;
    end
  endtask

  task automatic modelClear();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 32; i++) begin
        mReg[u][i]  = '0;
        mBusy[u][i] = 1'b0;
      end
  endtask

  task automatic idle();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 4; k++) rdIdx[u][k] = '0;
      we0[u] = 0; we1[u] = 0; iv[u] = 0;
      w0[u] = '0; w1[u] = '0; ir[u] = '0; d0[u] = '0; d1[u] = '0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) busA.ReadRegister[k*5 +: 5] = rdIdx[0][k];
    for (int k = 0; k < 3; k++) busB.ReadRegister[k*5 +: 5] = rdIdx[1][k];
    busA.RegWrite0 = we0[0]; busA.WriteRegister0 = w0[0]; busA.WriteData0 = d0[0];
    busA.RegWrite1 = we1[0]; busA.WriteRegister1 = w1[0]; busA.WriteData1 = d1[0];
    busA.IssueValid = iv[0]; busA.IssueRegister = ir[0];
    busB.RegWrite0 = we0[1]; busB.WriteRegister0 = w0[1]; busB.WriteData0 = d0[1];
    busB.RegWrite1 = we1[1]; busB.WriteRegister1 = w1[1]; busB.WriteData1 = d1[1];
    busB.IssueValid = iv[1]; busB.IssueRegister = ir[1];
  endtask

  task automatic checkComb();
    logic [31:0] expD, gotD;
    bit expB, gotB, expIr, gotIr;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < nRd[u]; k++) begin
        modelRead(u, rdIdx[u][k], expD, expB);
        if (u == 0) begin gotD = busA.ReadData[k*32 +: 32]; gotB = busA.ReadBusy[k]; end
        else        begin gotD = busB.ReadData[k*32 +: 32]; gotB = busB.ReadBusy[k]; end
        checkVal($sformatf("u%0d_rdata%0d", u, k), gotD, expD);
        checkVal($sformatf("u%0d_rbusy%0d", u, k), 32'(gotB), 32'(expB));
      end
      expIr = inReset || !valid(u, ir[u]) || !mBusy[u][ir[u]];
      gotIr = (u == 0) ? busA.IssueReady : busB.IssueReady;
      checkVal($sformatf("u%0d_issueReady", u), 32'(gotIr), 32'(expIr));
    end
  endtask

  task automatic checkCount();
    checkVal("u0_busyCount", 32'(busA.BusyCount), 32'(countBusy(0)));
    checkVal("u1_busyCount", 32'(busB.BusyCount), 32'(countBusy(1)));
  endtask

  task automatic preEdge();
    drive();
    #1;
    checkComb();
  endtask

  task automatic postEdge();
    @(posedge CLK);
    modelUpdate();
    #1;
    checkCount();
  endtask

  task automatic doReset();
    RESET_N = 1'b0;
    drive();
    #1;
    modelClear();
    inReset = 1'b1;
    checkComb();
    checkCount();
    @(negedge CLK);
    RESET_N = 1'b1;
    inReset = 1'b0;
  endtask

  function automatic logic [4:0] randIdx();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 9));
  endfunction

  initial begin
    modelClear();
    idle();
    doReset();

    // x0 stays zero
    idle();
    we0[0] = 1; w0[0] = 5'd0; d0[0] = 32'h12345678;
    we0[1] = 1; w0[1] = 5'd0; d0[1] = 32'h12345678;
    rdIdx[0][0] = 0; rdIdx[0][1] = 0;
    preEdge();
    checkVal("t2_bypass_r0", busA.ReadData[31:0], 32'h0);
    postEdge();
    idle();
    preEdge();
    checkVal("t2_r0_p0", busA.ReadData[31:0], 32'h0);
    checkVal("t2_r0_p1", busA.ReadData[63:32], 32'h0);
    checkVal("t2_r0_busy", 32'(busA.ReadBusy), 32'h0);
    postEdge();

    // dual write to the same index
    idle();
    for (int u = 0; u < 2; u++) begin
      we0[u] = 1; w0[u] = 5'd4; d0[u] = 32'hAAAA0000;
      we1[u] = 1; w1[u] = 5'd4; d1[u] = 32'h5555FFFF;
      rdIdx[u][0] = 5'd4;
    end
    preEdge();
    checkVal("t3_bypass_same_cycle", busA.ReadData[31:0], 32'hAAAA0000);
    checkVal("t3_nobypass_same_cycle", busB.ReadData[31:0], 32'h0);
    postEdge();
    idle();
    rdIdx[0][0] = 5'd4; rdIdx[1][0] = 5'd4;
    preEdge();
    checkVal("t3_next_cycle", busB.ReadData[31:0], 32'hAAAA0000);
    postEdge();

    // scoreboard set / WAW stall / clear
    idle();
    iv[0] = 1; ir[0] = 5'd7; iv[1] = 1; ir[1] = 5'd7;
    preEdge();
    postEdge();
    checkVal("t4_count_set", 32'(busA.BusyCount), 32'd1);
    rdIdx[0][0] = 5'd7; rdIdx[1][0] = 5'd7;
    preEdge();
    checkVal("t4_readBusy", 32'(busA.ReadBusy[0]), 32'd1);
    checkVal("t4_issueReady", 32'(busA.IssueReady), 32'd0);
    postEdge();
    checkVal("t4_reissue_count", 32'(busA.BusyCount), 32'd1);
    idle();
    for (int u = 0; u < 2; u++) begin
      we1[u] = 1; w1[u] = 5'd7; d1[u] = 32'hDEADBEEF; rdIdx[u][0] = 5'd7;
    end
    preEdge();
    postEdge();
    checkVal("t4_count_clear", 32'(busA.BusyCount), 32'd0);
    idle();
    rdIdx[0][0] = 5'd7; rdIdx[1][0] = 5'd7;
    preEdge();
    checkVal("t4_readback", busA.ReadData[31:0], 32'hDEADBEEF);
    checkVal("t4_busy_clear", 32'(busA.ReadBusy[0]), 32'd0);
    postEdge();

    // issue and write on the same edge
    idle();
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1; ir[u] = 5'd9; we0[u] = 1; w0[u] = 5'd9; d0[u] = 32'h11111111;
    end
    preEdge();
    postEdge();
    idle();
    rdIdx[0][0] = 5'd9; rdIdx[1][0] = 5'd9;
    preEdge();
    checkVal("t5_data", busB.ReadData[31:0], 32'h11111111);
    checkVal("t5_busy", 32'(busA.ReadBusy[0]), 32'd1);
    checkVal("t5_count", 32'(busB.BusyCount), 32'd1);
    postEdge();

    // out-of-range indices on the 24-entry instance
    idle();
    we0[1] = 1; w0[1] = 5'd23; d0[1] = 32'h33333333;
    we1[1] = 1; w1[1] = 5'd30; d1[1] = 32'h44444444;
    preEdge();
    postEdge();
    idle();
    rdIdx[1][0] = 5'd23; rdIdx[1][1] = 5'd23; rdIdx[1][2] = 5'd30;
    iv[1] = 1; ir[1] = 5'd30;
    preEdge();
    checkVal("t6_p0", busB.ReadData[31:0], 32'h33333333);
    checkVal("t6_p1", busB.ReadData[63:32], 32'h33333333);
    checkVal("t6_r30", busB.ReadData[95:64], 32'h0);
    checkVal("t6_r30_ready", 32'(busB.IssueReady), 32'd1);
    postEdge();
    checkVal("t6_r30_issue", 32'(busB.BusyCount), 32'd1);
    idle();
    rdIdx[1][2] = 5'd23;
    preEdge();
    checkVal("t6_p2", busB.ReadData[95:64], 32'h33333333);
    postEdge();

    // mid-operation reset
    idle();
    for (int r = 1; r <= 3; r++) begin
      we0[0] = 1; w0[0] = 5'(r); d0[0] = 32'hC0DE0000 + 32'(r);
      iv[0] = (r == 3); ir[0] = 5'd5;
      preEdge();
      postEdge();
    end
    idle();
    rdIdx[0][0] = 5'd1; rdIdx[0][1] = 5'd3; ir[0] = 5'd5;
    we0[0] = 1; w0[0] = 5'd1; d0[0] = 32'hFFFF0001;
    doReset();
    checkVal("t1_ready_after", 32'(busA.IssueReady), 32'd1);

    // randomised traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      idle();
      for (int u = 0; u < 2; u++) begin
        for (int k = 0; k < 4; k++) rdIdx[u][k] = randIdx();
        we0[u] = ($urandom_range(0, 9) < 4); w0[u] = randIdx(); d0[u] = $urandom();
        we1[u] = ($urandom_range(0, 9) < 4); w1[u] = randIdx(); d1[u] = $urandom();
        if ($urandom_range(0, 3) == 0) w1[u] = w0[u];
        iv[u] = ($urandom_range(0, 1) == 1); ir[u] = randIdx();
      end
      if ($urandom_range(0, 199) == 0) doReset();
      else begin
        preEdge();
        postEdge();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
